bullet_controller: RTL
======================

BULLET_CONTROLLER -- requirements
Module: bullet_controller

Interface
REQ-001 Parameter SPEED, 4, pixels moved per frame by each active bullet.
REQ-002 Parameter COOLDOWN, 8, frames between successive accepted shots.
REQ-003 Clk  in  1  single system clock; all state changes on rising edge.
REQ-004 Reset_n  in  1  asynchronous, active-low reset.
REQ-005 frame_tick  in  1  one-Clk pulse per video frame (vsync-derived).
REQ-006 fire  in  1  level fire key from keyboard decoder.
REQ-007 PlayerX, PlayerY  in  10 each  shooter sprite centre.
REQ-008 dir  in  dir_t (2)  shooter facing direction, sampled at spawn.
REQ-009 OpponentX, OpponentY  in  10 each  opponent sprite centre.
REQ-010 outmaze  in  20 x 20  maze rows; bit [tx] of row [ty] set = wall tile.
REQ-011 BulletX, BulletY  out  3 x 10  top-left corner of each 4x4 bullet.
REQ-012 bullet_active  out  3 x 1  slot in flight.
REQ-013 hit  out  1  one-Clk pulse when any bullet strikes the opponent.

Function
REQ-014 Rising edge of fire (registered previous value) SHALL set a pending-shot flag; further edges before the next frame_tick are ignored.
REQ-015 All bullet movement, spawn and retirement SHALL occur only in the Clk cycle where frame_tick=1; outputs are registered and visible the following cycle.
REQ-016 Each slot SHALL be a two-state FSM: IDLE -> FLY on spawn; FLY -> IDLE on wall, screen edge or hit.
REQ-017 In FLY, each tick SHALL move the bullet SPEED pixels along its latched direction (up = -Y, down = +Y, left = -X, right = +X).
REQ-018 Moving left/up with coordinate < SPEED SHALL retire the slot without subtracting (no 10-bit wrap).
REQ-019 New position with X+4 > 640 or Y+4 > 480 SHALL retire the slot.
REQ-020 Otherwise, wall test uses centre pixel (X+2, Y+2): tile tx = cx/32, ty = cy/24; outmaze[ty][tx]=1 retires the slot; tiles outside 20x20 count as open.
REQ-021 On tick with pending set and cooldown counter = 0, the lowest-index IDLE slot SHALL spawn at (PlayerX-2, PlayerY-2), latch dir, not move that frame; cooldown reloads to COOLDOWN; pending clears.
REQ-022 Pending with no IDLE slot SHALL be dropped (pending clears, cooldown unchanged).
REQ-023 Pending while cooldown > 0 SHALL be dropped.
REQ-024 Cooldown SHALL decrement by 1 per tick, saturating at 0.
REQ-025 A slot retired on a tick SHALL NOT be reused for a spawn on that same tick.
REQ-026 BulletX/BulletY of an IDLE slot SHALL hold their last value; only bullet_active qualifies them.

Reset
REQ-027 Reset_n low SHALL immediately force all bullet_active=0, BulletX/BulletY=0, hit=0, pending=0, cooldown=0, fire-edge register=0.
REQ-028 Reset mid-flight SHALL discard all bullets; first shot after release needs a fresh fire edge.

Configuration
REQ-029 With BULLET_HIT_EN defined, a bullet whose 4x4 box overlaps the 16x16 box centred on (OpponentX, OpponentY) after movement SHALL retire and assert hit for one Clk; hit has priority over wall retirement on the same tick.
REQ-030 Without BULLET_HIT_EN, opponent inputs SHALL be unused and hit tied to 0.

Structure
REQ-031 Shared package game_pkg SHALL hold dir_t (DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT), NUM_BULLETS=3, BULLET_SIZE=4, SCREEN_W=640, SCREEN_H=480, TILE_W=32, TILE_H=24, MAZE_DIM=20.
REQ-032 Per-slot FSM, movement and retirement SHALL live in sub-module bullet_slot, instantiated NUM_BULLETS times; spawn arbitration and cooldown stay in bullet_controller.

Verification
REQ-033 Empty maze, Player (100,100), dir=RIGHT, fire edge, tick -> slot0 active at (98,98); next tick (102,98).
REQ-034 Four fire edges each spaced COOLDOWN+1 ticks -> slots 0,1,2 fill; fourth dropped, no slot changes.
REQ-035 Bullet at (4,50) moving left, SPEED=4 -> next tick X=0 active; following tick retired, no wrap to 1020.
REQ-036 outmaze[4][5]=1, bullet moving right at Y=100 -> retires on first tick its centre X reaches 160.
REQ-037 BULLET_HIT_EN, opponent at (200,98), bullet from (98,98) right -> hit pulses exactly once, slot retires same tick.
REQ-038 Reset_n low for 1 cycle with 3 bullets in flight -> all inactive immediately; held fire level spawns nothing until released and re-pressed.

Source files
------------

// File: rtl/game_pkg.sv
// game_pkg -- shared types and geometry for the bullet controller slice.
//   dir_t        : shooter facing direction
//   slot_state_t : per-bullet-slot state
//   screen, tile, maze and bullet geometry constants
package game_pkg;

  typedef enum logic [1:0] {
    DIR_UP,
    DIR_DOWN,
    DIR_LEFT,
    DIR_RIGHT
  } dir_t;

  typedef enum logic {
    SLOT_IDLE,
    SLOT_FLY
  } slot_state_t;

  localparam int unsigned NUM_BULLETS = 3;
  localparam int unsigned BULLET_SIZE = 4;
  localparam int unsigned SCREEN_W    = 640;
  localparam int unsigned SCREEN_H    = 480;
  localparam int unsigned TILE_W      = 32;
  localparam int unsigned TILE_H      = 24;
  localparam int unsigned MAZE_DIM    = 20;
  localparam int unsigned OPP_SIZE    = 16;
  localparam int unsigned COORD_W     = 10;

  typedef logic [COORD_W-1:0] coord_t;
  typedef logic [MAZE_DIM-1:0][MAZE_DIM-1:0] maze_t;

  // One spare bit so movement and box arithmetic never wraps.
  function automatic logic [COORD_W:0] widen(input coord_t c);
    return {1'b0, c};
  endfunction

endpackage

// File: rtl/bullet_controller_if.sv
// bullet_controller_if -- game-side signal bundle of the bullet controller.
//   frame_tick, fire, PlayerX/Y, dir, OpponentX/Y, outmaze : towards controller
//   BulletX/Y, bullet_active, hit                          : from controller
// master = game logic driving the controller, slave = the controller.
interface bullet_controller_if;
  import game_pkg::*;

  logic                                  frame_tick;
  logic                                  fire;
  coord_t                                PlayerX;
  coord_t                                PlayerY;
  dir_t                                  dir;
  coord_t                                OpponentX;
  coord_t                                OpponentY;
  maze_t                                 outmaze;
  logic [NUM_BULLETS-1:0][COORD_W-1:0]   BulletX;
  logic [NUM_BULLETS-1:0][COORD_W-1:0]   BulletY;
  logic [NUM_BULLETS-1:0]                bullet_active;
  logic                                  hit;

  modport master (
    output frame_tick, fire, PlayerX, PlayerY, dir, OpponentX, OpponentY, outmaze,
    input  BulletX, BulletY, bullet_active, hit
  );

  modport slave (
    input  frame_tick, fire, PlayerX, PlayerY, dir, OpponentX, OpponentY, outmaze,
    output BulletX, BulletY, bullet_active, hit
  );

endinterface

// File: rtl/bullet_slot.sv
// bullet_slot -- one bullet: IDLE/FLY state, movement and retirement.
//   clk, rst_n        : clock, async active-low reset
//   tick              : frame tick; all changes happen only on it
//   spawn, spawn_x/y, spawn_dir : start flying from this position/direction
//   opp_x, opp_y      : opponent centre (used only with BULLET_HIT_EN)
//   outmaze           : wall map, row [ty] bit [tx]
//   active, pos_x/y   : slot in flight and its top-left corner (held when idle)
//   hit_now           : combinational, this slot strikes the opponent this tick
// Build macro: BULLET_HIT_EN enables opponent collision.
module bullet_slot
  import game_pkg::*;
#(
  parameter int unsigned SPEED = 4
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   tick,
  input  logic   spawn,
  input  coord_t spawn_x,
  input  coord_t spawn_y,
  input  dir_t   spawn_dir,
  input  coord_t opp_x,
  input  coord_t opp_y,
  input  maze_t  outmaze,
  output logic   active,
  output coord_t pos_x,
  output coord_t pos_y,
  output logic   hit_now
);

  localparam logic [COORD_W:0] STEP = (COORD_W+1)'(SPEED);
  localparam logic [COORD_W:0] SZ   = (COORD_W+1)'(BULLET_SIZE);
  localparam logic [COORD_W:0] HALF = (COORD_W+1)'(BULLET_SIZE / 2);
  localparam logic [COORD_W:0] SW   = (COORD_W+1)'(SCREEN_W);
  localparam logic [COORD_W:0] SH   = (COORD_W+1)'(SCREEN_H);
  localparam logic [COORD_W:0] TW   = (COORD_W+1)'(TILE_W);
  localparam logic [COORD_W:0] TH   = (COORD_W+1)'(TILE_H);
  localparam logic [COORD_W:0] MD   = (COORD_W+1)'(MAZE_DIM);

  slot_state_t state_q, state_d;
  coord_t      x_q, x_d, y_q, y_d;
  dir_t        dir_q, dir_d;

  logic [COORD_W:0] cur_x, cur_y, nx, ny, cx, cy, tx, ty;
  logic             underflow, off_screen, wall, strike;

  // Candidate position after one step plus the retirement conditions.
  always_comb begin
    cur_x     = widen(x_q);
    cur_y     = widen(y_q);
    nx        = cur_x;
    ny        = cur_y;
    underflow = 1'b0;
    case (dir_q)
      DIR_UP:    if (cur_y < STEP) underflow = 1'b1; else ny = cur_y - STEP;
      DIR_DOWN:  ny = cur_y + STEP;
      DIR_LEFT:  if (cur_x < STEP) underflow = 1'b1; else nx = cur_x - STEP;
      DIR_RIGHT: nx = cur_x + STEP;
      default:   ;
    endcase
    off_screen = (nx + SZ > SW) || (ny + SZ > SH);
    cx   = nx + HALF;
    cy   = ny + HALF;
    tx   = cx / TW;
    ty   = cy / TH;
    wall = 1'b0;
    if (tx < MD && ty < MD) wall = outmaze[ty[4:0]][tx[4:0]];
  end

`ifdef BULLET_HIT_EN
  localparam logic [COORD_W:0] OPP_LO = (COORD_W+1)'(OPP_SIZE / 2);
  localparam logic [COORD_W:0] OPP_HI = (COORD_W+1)'(OPP_SIZE / 2 - 1);
  logic [COORD_W:0] ox, oy;

  // Boxes overlap when neither lies wholly to one side of the other;
  // the opponent's lower bound is moved to the bullet side to stay unsigned.
  always_comb begin
    ox     = widen(opp_x);
    oy     = widen(opp_y);
    strike = (nx <= ox + OPP_HI) && (nx + SZ - 1'b1 + OPP_LO >= ox) &&
             (ny <= oy + OPP_HI) && (ny + SZ - 1'b1 + OPP_LO >= oy);
  end
`else
  logic unused_opp;
  assign unused_opp = ^{opp_x, opp_y};
  assign strike     = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    dir_d   = dir_q;
    hit_now = 1'b0;
    case (state_q)
      SLOT_IDLE: begin
        if (tick && spawn) begin
          state_d = SLOT_FLY;
          x_d     = spawn_x;
          y_d     = spawn_y;
          dir_d   = spawn_dir;
        end
      end
      SLOT_FLY: begin
        if (tick) begin
          // Retirement keeps the last in-flight position on the outputs.
          if (underflow) begin
            state_d = SLOT_IDLE;
          end else if (strike) begin
            state_d = SLOT_IDLE;
            hit_now = 1'b1;
          end else if (off_screen || wall) begin
            state_d = SLOT_IDLE;
          end else begin
            x_d = nx[COORD_W-1:0];
            y_d = ny[COORD_W-1:0];
          end
        end
      end
      default: state_d = SLOT_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SLOT_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      dir_q   <= DIR_UP;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      dir_q   <= dir_d;
    end
  end

  assign active = (state_q == SLOT_FLY);
  assign pos_x  = x_q;
  assign pos_y  = y_q;

endmodule

// File: rtl/bullet_controller.sv
// bullet_controller -- fire-edge capture, shot cooldown and spawn arbitration
// over NUM_BULLETS bullet_slot instances.
//   Clk, Reset_n : clock, async active-low reset
//   bus          : bullet_controller_if.slave (inputs: frame_tick, fire,
//                  PlayerX/Y, dir, OpponentX/Y, outmaze; outputs: BulletX/Y,
//                  bullet_active, hit)
// Parameters: SPEED (pixels per frame), COOLDOWN (frames between shots).
// Build macro: BULLET_HIT_EN enables opponent hits; otherwise hit stays 0.
module bullet_controller
  import game_pkg::*;
#(
  parameter int unsigned SPEED    = 4,
  parameter int unsigned COOLDOWN = 8
) (
  input  logic               Clk,
  input  logic               Reset_n,
  bullet_controller_if.slave bus
);

  localparam int unsigned     CD_W      = $clog2(COOLDOWN + 2);
  localparam logic [CD_W-1:0] CD_RELOAD = CD_W'(COOLDOWN);

  logic            fire_q, armed_q, pending_q, hit_q;
  logic [CD_W-1:0] cooldown_q;

  logic                   fire_edge, want_shot, spawn_ok, found;
  logic [NUM_BULLETS-1:0] spawn_vec, active_vec, hit_vec;
  coord_t                 spawn_x, spawn_y;
  logic [NUM_BULLETS-1:0][COORD_W-1:0] pos_x_vec, pos_y_vec;

  // armed_q only rises once fire has been seen released, so a key held
  // through reset cannot look like a fresh press when reset lifts.
  always_comb begin
    fire_edge = bus.fire & ~fire_q & armed_q;
    want_shot = pending_q | fire_edge;
    spawn_ok  = bus.frame_tick & want_shot & (cooldown_q == '0);
    spawn_x   = bus.PlayerX - coord_t'(BULLET_SIZE / 2);
    spawn_y   = bus.PlayerY - coord_t'(BULLET_SIZE / 2);
    // Arbitration uses pre-tick activity: a slot retiring this tick is
    // still active here and so cannot be reused on the same tick.
    spawn_vec = '0;
    found     = 1'b0;
    for (int unsigned i = 0; i < NUM_BULLETS; i++) begin
      if (!found && !active_vec[i]) begin
        spawn_vec[i] = spawn_ok;
        found        = 1'b1;
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      fire_q     <= 1'b0;
      armed_q    <= 1'b0;
      pending_q  <= 1'b0;
      cooldown_q <= '0;
      hit_q      <= 1'b0;
    end else begin
      fire_q  <= bus.fire;
      armed_q <= armed_q | ~bus.fire;
      hit_q   <= |hit_vec;
      if (bus.frame_tick) begin
        pending_q <= 1'b0;
        if (|spawn_vec)              cooldown_q <= CD_RELOAD;
        else if (cooldown_q != '0)   cooldown_q <= cooldown_q - CD_W'(1);
      end else if (fire_edge) begin
        pending_q <= 1'b1;
      end
    end
  end

  for (genvar g = 0; g < NUM_BULLETS; g++) begin : g_slot
    bullet_slot #(.SPEED(SPEED)) u_slot (
      .clk       (Clk),
      .rst_n     (Reset_n),
      .tick      (bus.frame_tick),
      .spawn     (spawn_vec[g]),
      .spawn_x   (spawn_x),
      .spawn_y   (spawn_y),
      .spawn_dir (bus.dir),
      .opp_x     (bus.OpponentX),
      .opp_y     (bus.OpponentY),
      .outmaze   (bus.outmaze),
      .active    (active_vec[g]),
      .pos_x     (pos_x_vec[g]),
      .pos_y     (pos_y_vec[g]),
      .hit_now   (hit_vec[g])
    );
  end

  assign bus.BulletX       = pos_x_vec;
  assign bus.BulletY       = pos_y_vec;
  assign bus.bullet_active = active_vec;
  assign bus.hit           = hit_q;

endmodule
